// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract sequencer driving an external 4-bit ripple adder,
// one nibble per cycle LSB first, with the inter-nibble carry held in a flop.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic                   c_in,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out,
    output logic                   ovf
);
    // state | meaning
    // IDLE  | waiting for start; adder inputs held at 0
    // RUN   | one nibble per cycle through the adder, idx selects the nibble
    // DONE  | one-cycle done pulse, result registers stable
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_reg_q, a_reg_d;
    logic [W-1:0]     b_reg_q, b_reg_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_reg_d = a_reg_q;
        b_reg_d = b_reg_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
                    a_reg_d = a_in;
                    b_reg_d = op_sub ? ~b_in : b_in;
                    carry_d = op_sub ? 1'b1 : c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[4*idx_q +: 4] = add_s;
                carry_d             = add_cout;
                if (idx_q == IDX_LAST) begin
                    c_out_d = add_cout;
                    ovf_d   = (a_reg_q[W-1] == b_reg_q[W-1]) && (add_s[3] != a_reg_q[W-1]);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_reg_q <= '0;
            b_reg_q <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_reg_q <= a_reg_d;
            b_reg_q <= b_reg_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == ST_RUN) begin
            add_a   = a_reg_q[4*idx_q +: 4];
            add_b   = b_reg_q[4*idx_q +: 4];
            add_cin = carry_q;
        end
    end

    assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
